// File: rtl/alu_dp_pkg.sv
// Shared definitions for the pipelined register-file ALU datapath:
// op codes, flag bit positions and control-word field offsets.
package alu_dp_pkg;

  localparam logic [2:0] OP_PASS = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_AND  = 3'd3;
  localparam logic [2:0] OP_OR   = 3'd4;
  localparam logic [2:0] OP_XOR  = 3'd5;
  localparam logic [2:0] OP_SHL  = 3'd6;
  localparam logic [2:0] OP_SHR  = 3'd7;

  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  localparam int unsigned OP_LSB = 0;
  localparam int unsigned OP_W   = 3;

  // Control word layout: {dest, src_b, src_a, op}, each selector SW bits wide.
  function automatic int unsigned src_a_lsb(input int unsigned sw);
    return OP_W + 0 * sw;
  endfunction

  function automatic int unsigned src_b_lsb(input int unsigned sw);
    return OP_W + sw;
  endfunction

  function automatic int unsigned dest_lsb(input int unsigned sw);
    return OP_W + 2 * sw;
  endfunction

  function automatic int unsigned ctrl_width(input int unsigned sw);
    return OP_W + 3 * sw;
  endfunction

endpackage

// File: rtl/dp_alu.sv
// Combinational ALU: eight operations plus {Z, N, C, V} status flags.
module dp_alu
  import alu_dp_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  localparam int unsigned SHW = $clog2(WIDTH);

  logic [WIDTH:0]   sum;
  logic [SHW-1:0]   shamt;
  logic             carry;
  logic             ovf;

  assign shamt = b[SHW-1:0];

  always_comb begin
    sum    = '0;
    result = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    unique case (op)
      OP_PASS: result = a;
      OP_ADD: begin
        sum    = {1'b0, a} + {1'b0, b};
        result = sum[WIDTH-1:0];
        carry  = sum[WIDTH];
        ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      // Extended subtraction: the top bit is the unsigned borrow (a < b).
      OP_SUB: begin
        sum    = {1'b0, a} - {1'b0, b};
        result = sum[WIDTH-1:0];
        carry  = sum[WIDTH];
        ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SHL:  result = a << shamt;
      OP_SHR:  result = a >> shamt;
      default: result = a;
    endcase
  end

  always_comb begin
    flags         = '0;
    flags[FLAG_Z] = (result == '0);
    flags[FLAG_N] = result[WIDTH-1];
    flags[FLAG_C] = carry;
    flags[FLAG_V] = ovf;
  end

endmodule

// File: rtl/alu_datapath_pipe.sv
// Two-stage register-file datapath: issue (operand fetch with forwarding)
// then execute/writeback to a register or the output port.
module alu_datapath_pipe
  import alu_dp_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned NREGS = 4,
  localparam int unsigned SW    = $clog2(NREGS) + 1,
  localparam int unsigned CW    = ctrl_width(SW)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [CW-1:0]    ctrl,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  output logic [3:0]       flags
);

  localparam int unsigned RI     = $clog2(NREGS);
  localparam int unsigned A_LSB  = src_a_lsb(SW);
  localparam int unsigned B_LSB  = src_b_lsb(SW);
  localparam int unsigned D_LSB  = dest_lsb(SW);

  logic [WIDTH-1:0] regs [NREGS];

  logic [2:0]       op_in;
  logic [SW-1:0]    src_a;
  logic [SW-1:0]    src_b;
  logic [SW-1:0]    dest_in;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;

  logic             ex_valid;
  logic [2:0]       ex_op;
  logic [SW-1:0]    ex_dest;
  logic [WIDTH-1:0] ex_a;
  logic [WIDTH-1:0] ex_b;

  logic [WIDTH-1:0] alu_result;
  logic [3:0]       alu_flags;
  logic             wb_reg;

  assign op_in   = ctrl[OP_LSB +: OP_W];
  assign src_a   = ctrl[A_LSB +: SW];
  assign src_b   = ctrl[B_LSB +: SW];
  assign dest_in = ctrl[D_LSB +: SW];
  assign wb_reg  = ex_valid && !ex_dest[SW-1];

  // Operand select: data_in, else the result being written this edge, else the register.
  always_comb begin
    opa = regs[src_a[RI-1:0]];
    opb = regs[src_b[RI-1:0]];
    if (src_a[SW-1]) begin
      opa = data_in;
    end else if (wb_reg && (ex_dest[RI-1:0] == src_a[RI-1:0])) begin
      opa = alu_result;
    end
    if (src_b[SW-1]) begin
      opb = data_in;
    end else if (wb_reg && (ex_dest[RI-1:0] == src_b[RI-1:0])) begin
      opb = alu_result;
    end
  end

  dp_alu #(.WIDTH(WIDTH)) u_alu (
    .op     (ex_op),
    .a      (ex_a),
    .b      (ex_b),
    .result (alu_result),
    .flags  (alu_flags)
  );

  // Issue stage registers plus writeback to register file, output and flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid  <= 1'b0;
      ex_op     <= '0;
      ex_dest   <= '0;
      ex_a      <= '0;
      ex_b      <= '0;
      data_out  <= '0;
      out_valid <= 1'b0;
      flags     <= '0;
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      ex_valid  <= in_valid;
      if (in_valid) begin
        ex_op   <= op_in;
        ex_dest <= dest_in;
        ex_a    <= opa;
        ex_b    <= opb;
      end
      out_valid <= ex_valid && ex_dest[SW-1];
      if (ex_valid) begin
        flags <= alu_flags;
        if (ex_dest[SW-1]) begin
          data_out <= alu_result;
        end else begin
          regs[ex_dest[RI-1:0]] <= alu_result;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_datapath_pipe.sv
// Directed and randomized checks of alu_datapath_pipe against a sequential
// instruction-level reference model (WIDTH=8, NREGS=4).
module tb_alu_datapath_pipe;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned NREGS = 4;
  localparam int unsigned CW    = 12;
  localparam logic [2:0]  IO    = 3'b100;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic [CW-1:0]    ctrl;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             out_valid;
  logic [3:0]       flags;

  int vectors     = 0;
  int miscompares = 0;

  // Reference state: architectural registers, output, flags, one word in flight.
  int          m_regs [NREGS];
  logic [7:0]  m_dout;
  logic        m_ov;
  logic [3:0]  m_flags;
  logic        p_valid;
  logic [11:0] p_ctrl;
  logic [7:0]  p_din;

  alu_datapath_pipe #(.WIDTH(WIDTH), .NREGS(NREGS)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .ctrl      (ctrl),
    .data_in   (data_in),
    .data_out  (data_out),
    .out_valid (out_valid),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] rsel(input int r);
    return {1'b0, 2'(r)};
  endfunction

  function automatic logic [11:0] mk(input logic [2:0] op, input logic [2:0] sa,
                                     input logic [2:0] sb, input logic [2:0] d);
    return {d, sb, sa, op};
  endfunction

  task automatic ref_alu(input int op, input int a, input int b,
                         output int res, output logic [3:0] f);
    int sa, sb, full, sres;
    logic c, v;
    c  = 1'b0;
    v  = 1'b0;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    case (op)
      1: begin
        full = a + b;
        c    = (full > 255);
        sres = sa + sb;
        v    = (sres > 127) || (sres < -128);
      end
      2: begin
        full = a - b;
        c    = (a < b);
        sres = sa - sb;
        v    = (sres > 127) || (sres < -128);
      end
      3: full = a & b;
      4: full = a | b;
      5: full = a ^ b;
      6: full = a << (b % 8);
      7: full = a >> (b % 8);
      default: full = a;
    endcase
    res = full & 255;
    f   = {res == 0, res >= 128, c, v};
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) m_regs[i] = 0;
    m_dout  = '0;
    m_ov    = 1'b0;
    m_flags = '0;
    p_valid = 1'b0;
    p_ctrl  = '0;
    p_din   = '0;
  endtask

  // Execute the word in flight in program order, then accept the driven one.
  task automatic model_edge();
    int a, b, res;
    logic [3:0] f;
    m_ov = 1'b0;
    if (p_valid) begin
      a = p_ctrl[5] ? int'(p_din) : m_regs[p_ctrl[4:3]];
      b = p_ctrl[8] ? int'(p_din) : m_regs[p_ctrl[7:6]];
      ref_alu(int'(p_ctrl[2:0]), a, b, res, f);
      m_flags = f;
      if (p_ctrl[11]) begin
        m_dout = 8'(res);
        m_ov   = 1'b1;
      end else begin
        m_regs[p_ctrl[10:9]] = res;
      end
    end
    p_valid = in_valid;
    if (in_valid) begin
      p_ctrl = ctrl;
      p_din  = data_in;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, ".data_out"}, data_out, m_dout);
    chk({tag, ".out_valid"}, 8'(out_valid), 8'(m_ov));
    chk({tag, ".flags"}, 8'(flags), 8'(m_flags));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    chk_outputs(tag);
    @(negedge clk);
  endtask

  task automatic send(input logic [11:0] w, input logic [7:0] din, input string tag);
    in_valid = 1'b1;
    ctrl     = w;
    data_in  = din;
    tick(tag);
  endtask

  task automatic idle(input string tag);
    in_valid = 1'b0;
    ctrl     = 12'($urandom);
    data_in  = 8'($urandom);
    tick(tag);
  endtask

  // r0 <- x, r1 <- y, OUT <- op r0,r1, then let it retire.
  task automatic op2(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y,
                     input string tag);
    send(mk(3'd0, IO, IO, rsel(0)), x, tag);
    send(mk(3'd0, IO, IO, rsel(1)), y, tag);
    send(mk(op, rsel(0), rsel(1), IO), 8'h00, tag);
    idle(tag);
  endtask

  initial begin
    reset    = 1'b0;
    in_valid = 1'b0;
    ctrl     = '0;
    data_in  = '0;
    model_reset();
    #1;
    chk_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    op2(3'd2, 8'h05, 8'h03, "sub5_3");
    chk("sub5_3.value", data_out, 8'h02);
    chk("sub5_3.pulse", 8'(out_valid), 8'h01);
    chk("sub5_3.flags", 8'(flags), 8'h00);
    idle("sub5_3.after");
    chk("sub5_3.pulse_end", 8'(out_valid), 8'h00);

    send(mk(3'd0, IO, IO, rsel(0)), 8'h10, "fwd");
    send(mk(3'd1, rsel(0), rsel(0), IO), 8'h00, "fwd");
    idle("fwd");
    chk("fwd.value", data_out, 8'h20);

    op2(3'd1, 8'h7F, 8'h01, "add_ovf");
    chk("add_ovf.value", data_out, 8'h80);
    chk("add_ovf.flags", 8'(flags), 8'h05);
    op2(3'd1, 8'hFF, 8'h01, "add_carry");
    chk("add_carry.value", data_out, 8'h00);
    chk("add_carry.flags", 8'(flags), 8'h0A);
    op2(3'd2, 8'h00, 8'h01, "sub_borrow");
    chk("sub_borrow.value", data_out, 8'hFF);
    chk("sub_borrow.flags", 8'(flags), 8'h06);
    op2(3'd6, 8'h81, 8'h01, "shl");
    chk("shl.value", data_out, 8'h02);
    chk("shl.flags", 8'(flags), 8'h00);
    op2(3'd7, 8'h81, 8'h09, "shr");
    chk("shr.value", data_out, 8'h40);

    for (int i = 0; i < 5; i++) idle("idle");
    chk("idle.value", data_out, 8'h40);
    chk("idle.flags", 8'(flags), 8'h00);
    send(mk(3'd0, rsel(0), rsel(0), IO), 8'h00, "idle.r0");
    idle("idle.r0");
    chk("idle.r0_value", data_out, 8'h81);

    // Reset while r2 <- 0xAA is in flight: the write must be lost.
    send(mk(3'd0, IO, IO, rsel(2)), 8'hAA, "rst_mid");
    in_valid = 1'b0;
    reset    = 1'b0;
    #1;
    model_reset();
    chk_outputs("rst_mid.async");
    @(posedge clk);
    #1;
    chk_outputs("rst_mid.held");
    @(negedge clk);
    reset = 1'b1;
    send(mk(3'd0, rsel(2), rsel(2), IO), 8'h00, "rst_r2");
    idle("rst_r2");
    chk("rst_r2.value", data_out, 8'h00);
    chk("rst_r2.pulse", 8'(out_valid), 8'h01);
    send(mk(3'd0, IO, IO, rsel(3)), 8'h5A, "post_rst");
    send(mk(3'd0, rsel(3), rsel(3), IO), 8'h00, "post_rst");
    idle("post_rst");
    chk("post_rst.value", data_out, 8'h5A);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 4) != 0) send(12'($urandom), 8'($urandom), "rand");
      else idle("rand");
    end
    idle("drain");
    for (int r = 0; r < NREGS; r++) begin
      send(mk(3'd0, rsel(r), rsel(r), IO), 8'h00, "readback");
      idle("readback");
      chk("readback.reg", data_out, 8'(m_regs[r]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
